// File: rtl/register_operand_fetch.sv
// Register operand fetch stage: decodes the register slots an instruction
// uses, then streams the reads over READ_PORTS register-file ports.
module register_operand_fetch #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned READ_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         instr_valid,
  input  logic [27:0]                  instr,
  output logic                         instr_ready,
  input  logic                         flush,
  output logic [READ_PORTS-1:0]        rf_ren,
  output logic [4*READ_PORTS-1:0]      rf_raddr,
  input  logic [DATA_W*READ_PORTS-1:0] rf_rdata,
  output logic                         op_valid,
  input  logic                         op_ready,
  output logic [DATA_W-1:0]            op_rn,
  output logic [DATA_W-1:0]            op_rm,
  output logic [DATA_W-1:0]            op_rs,
  output logic [DATA_W-1:0]            op_rd,
  output logic [3:0]                   op_mask
);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_e;

  state_e                   state_q, state_d;
  logic [3:0][3:0]          idx_q, idx_d;
  logic [3:0]               mask_q, mask_d;
  logic [3:0]               pend_q, pend_d;
  logic [3:0][DATA_W-1:0]   op_q, op_d;

  logic [3:0][3:0]          dec_idx;
  logic [3:0]               dec_mask;
  logic [3:0]               grant;
  logic [3:0][1:0]          slot_port;

  // Slot order everywhere: 0=rn, 1=rm, 2=rs, 3=rd. First matching class wins.
  always_comb begin
    dec_idx  = '0;
    dec_mask = '0;
    if (instr[27:22] == 6'b000000 && instr[7:4] == 4'b1001) begin
      dec_idx[1] = instr[3:0];   dec_mask[1] = 1'b1;
      dec_idx[2] = instr[11:8];  dec_mask[2] = 1'b1;
      if (instr[21]) begin
        dec_idx[0] = instr[15:12]; dec_mask[0] = 1'b1;
      end
    end else if (instr[27:23] == 5'b00001 && instr[7:4] == 4'b1001) begin
      dec_idx[1] = instr[3:0];   dec_mask[1] = 1'b1;
      dec_idx[2] = instr[11:8];  dec_mask[2] = 1'b1;
    end else if (instr[27:23] == 5'b00010 && instr[21:20] == 2'b00 && instr[11:4] == 8'h09) begin
      dec_idx[0] = instr[19:16]; dec_mask[0] = 1'b1;
      dec_idx[1] = instr[3:0];   dec_mask[1] = 1'b1;
    end else if (instr[27:4] == 24'h12FFF1) begin
      dec_idx[0] = instr[3:0];   dec_mask[0] = 1'b1;
    end else if (instr[27:25] == 3'b000 && instr[7] && instr[4]) begin
      dec_idx[0] = instr[19:16]; dec_mask[0] = 1'b1;
      dec_idx[1] = instr[3:0];   dec_mask[1] = !instr[22];
      dec_idx[3] = instr[15:12]; dec_mask[3] = !instr[20];
    end else if (instr[27:26] == 2'b00) begin
      dec_idx[0] = instr[19:16];
      dec_mask[0] = !(instr[24:21] == 4'b1101 || instr[24:21] == 4'b1111);
      dec_idx[1] = instr[3:0];   dec_mask[1] = !instr[25];
      dec_idx[2] = instr[11:8];  dec_mask[2] = !instr[25] && instr[4];
    end else if (instr[27:26] == 2'b01 && (!instr[25] || !instr[4])) begin
      dec_idx[0] = instr[19:16]; dec_mask[0] = 1'b1;
      dec_idx[1] = instr[3:0];   dec_mask[1] = instr[25];
      dec_idx[3] = instr[15:12]; dec_mask[3] = !instr[20];
    end else if (instr[27:25] == 3'b100) begin
      dec_idx[0] = instr[19:16]; dec_mask[0] = 1'b1;
    end
    // Unused slot indices stay zero so they never leak onto rf_raddr.
    for (int unsigned s = 0; s < 4; s++) begin
      if (!dec_mask[s]) dec_idx[s] = '0;
    end
  end

  // Pack pending slots onto the lowest-numbered ports in rn, rm, rs, rd order.
  always_comb begin
    int unsigned used;
    used      = 0;
    rf_ren    = '0;
    rf_raddr  = '0;
    grant     = '0;
    slot_port = '0;
    if (state_q == FETCH) begin
      for (int unsigned s = 0; s < 4; s++) begin
        if (pend_q[s] && used < READ_PORTS) begin
          rf_ren[used]          = 1'b1;
          rf_raddr[4*used +: 4] = idx_q[s];
          slot_port[s]          = 2'(used);
          grant[s]              = 1'b1;
          used                  = used + 1;
        end
      end
    end
  end

  always_comb begin
    int unsigned base;
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    pend_d  = pend_q;
    op_d    = op_q;
    base    = 0;
    if (flush) begin
      state_d = IDLE;
      pend_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: if (instr_valid) begin
          idx_d   = dec_idx;
          mask_d  = dec_mask;
          pend_d  = dec_mask;
          op_d    = '0;
          state_d = (dec_mask != '0) ? FETCH : DONE;
        end
        FETCH: begin
          for (int unsigned s = 0; s < 4; s++) begin
            if (grant[s]) begin
              base    = DATA_W * 32'(slot_port[s]);
              op_d[s] = rf_rdata[base +: DATA_W];
            end
          end
          pend_d = pend_q & ~grant;
          if ((pend_q & ~grant) == '0) state_d = DONE;
        end
        DONE: if (op_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      op_q    <= op_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign op_valid    = (state_q == DONE);
  assign op_rn       = op_q[0];
  assign op_rm       = op_q[1];
  assign op_rs       = op_q[2];
  assign op_rd       = op_q[3];
  assign op_mask     = mask_q;

endmodule

// File: tb/tb_register_operand_fetch.sv
// Directed bench: a 2-port and a 1-port instance, each fed by a register-file model.
module tb_register_operand_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 2-port instance
  logic        iv_a = 1'b0, fl_a = 1'b0, ordy_a = 1'b0;
  logic [27:0] ins_a = '0;
  logic        irdy_a, ov_a;
  logic [1:0]  ren_a;
  logic [7:0]  raddr_a;
  logic [63:0] rdata_a;
  logic [31:0] rn_a, rm_a, rs_a, rd_a;
  logic [3:0]  mask_a;

  // 1-port instance
  logic        iv_b = 1'b0, fl_b = 1'b0, ordy_b = 1'b0;
  logic [27:0] ins_b = '0;
  logic        irdy_b, ov_b;
  logic [0:0]  ren_b;
  logic [3:0]  raddr_b;
  logic [31:0] rdata_b;
  logic [31:0] rn_b, rm_b, rs_b, rd_b;
  logic [3:0]  mask_b;

  register_operand_fetch #(.DATA_W(32), .READ_PORTS(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .instr_valid(iv_a), .instr(ins_a), .instr_ready(irdy_a),
    .flush(fl_a), .rf_ren(ren_a), .rf_raddr(raddr_a), .rf_rdata(rdata_a),
    .op_valid(ov_a), .op_ready(ordy_a), .op_rn(rn_a), .op_rm(rm_a), .op_rs(rs_a),
    .op_rd(rd_a), .op_mask(mask_a)
  );

  register_operand_fetch #(.DATA_W(32), .READ_PORTS(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .instr_valid(iv_b), .instr(ins_b), .instr_ready(irdy_b),
    .flush(fl_b), .rf_ren(ren_b), .rf_raddr(raddr_b), .rf_rdata(rdata_b),
    .op_valid(ov_b), .op_ready(ordy_b), .op_rn(rn_b), .op_rm(rm_b), .op_rs(rs_b),
    .op_rd(rd_b), .op_mask(mask_b)
  );

  function automatic logic [31:0] rfv(input logic [3:0] i);
    return 32'hC0DE_0000 | {16'h0, i, i, i, i};
  endfunction

  always_comb begin
    for (int p = 0; p < 2; p++) rdata_a[32*p +: 32] = rfv(raddr_a[4*p +: 4]);
    rdata_b = rfv(raddr_b);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction through the 1-port instance. idx packs {rd,rs,rm,rn}.
  task automatic run_b(input string tag, input logic [27:0] ins, input logic [3:0] m,
                       input logic [15:0] idx);
    cyc(); iv_b = 1'b1; ins_b = ins; #2;
    check({tag, "_rdy"}, irdy_b, 1'b1);
    cyc(); iv_b = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (m[s]) begin
        #2;
        check($sformatf("%s_ren%0d", tag, s), ren_b, 1'b1);
        check($sformatf("%s_addr%0d", tag, s), raddr_b, idx[4*s +: 4]);
        check($sformatf("%s_ov%0d", tag, s), ov_b, 1'b0);
        cyc();
      end
    end
    #2;
    check({tag, "_ov"}, ov_b, 1'b1);
    check({tag, "_ren_done"}, ren_b, 1'b0);
    check({tag, "_mask"}, mask_b, m);
    check({tag, "_rn"}, rn_b, m[0] ? rfv(idx[3:0])   : 32'h0);
    check({tag, "_rm"}, rm_b, m[1] ? rfv(idx[7:4])   : 32'h0);
    check({tag, "_rs"}, rs_b, m[2] ? rfv(idx[11:8])  : 32'h0);
    check({tag, "_rd"}, rd_b, m[3] ? rfv(idx[15:12]) : 32'h0);
    ordy_b = 1'b1;
    cyc(); ordy_b = 1'b0; #2;
    check({tag, "_idle"}, irdy_b, 1'b1);
    check({tag, "_ov_off"}, ov_b, 1'b0);
  endtask

  initial begin
    #2;
    check("rst_rdy_a", irdy_a, 1'b1);
    check("rst_ov_a", ov_a, 1'b0);
    check("rst_ren_a", ren_a, 2'b00);
    check("rst_raddr_a", raddr_a, 8'h00);
    check("rst_mask_a", mask_a, 4'h0);
    check("rst_rn_a", rn_a, 32'h0);
    check("rst_ov_b", ov_b, 1'b0);
    #20 rst_n = 1'b1;

    // ADD r1,r2,r3 LSL r4 on two ports
    cyc(); iv_a = 1'b1; ins_a = 28'h0821413; #2;
    check("add_rdy", irdy_a, 1'b1);
    cyc(); iv_a = 1'b0; #2;
    check("add_c1_ren", ren_a, 2'b11);
    check("add_c1_addr", raddr_a, 8'h32);
    cyc(); #2;
    check("add_c2_ren", ren_a, 2'b01);
    check("add_c2_addr", raddr_a, 8'h04);
    check("add_c2_ov", ov_a, 1'b0);
    cyc(); #2;
    check("add_ov", ov_a, 1'b1);
    check("add_mask", mask_a, 4'b0111);
    check("add_rn", rn_a, rfv(4'd2));
    check("add_rm", rm_a, rfv(4'd3));
    check("add_rs", rs_a, rfv(4'd4));
    check("add_rd", rd_a, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(); #2;
      check($sformatf("stall%0d_ov", i), ov_a, 1'b1);
      check($sformatf("stall%0d_rdy", i), irdy_a, 1'b0);
      check($sformatf("stall%0d_rs", i), rs_a, rfv(4'd4));
      check($sformatf("stall%0d_mask", i), mask_a, 4'b0111);
    end
    ordy_a = 1'b1; #1;
    check("hs_ov", ov_a, 1'b1);
    cyc(); ordy_a = 1'b0; #2;
    check("hs_idle", irdy_a, 1'b1);
    check("hs_ov_off", ov_a, 1'b0);

    // MOV r0,#5: no slots, bundle valid one cycle after acceptance
    cyc(); iv_a = 1'b1; ins_a = 28'h3A00005; #2;
    check("mov_rdy", irdy_a, 1'b1);
    cyc(); iv_a = 1'b0; #2;
    check("mov_ov", ov_a, 1'b1);
    check("mov_ren", ren_a, 2'b00);
    check("mov_mask", mask_a, 4'h0);
    check("mov_rn", rn_a, 32'h0);
    check("mov_rm", rm_a, 32'h0);
    check("mov_rs", rs_a, 32'h0);
    ordy_a = 1'b1;
    cyc(); ordy_a = 1'b0; #2;
    check("mov_idle", irdy_a, 1'b1);

    // Flush during FETCH of the ADD
    cyc(); iv_a = 1'b1; ins_a = 28'h0821413;
    cyc(); iv_a = 1'b0; #2;
    check("fl_fetch_ren", ren_a, 2'b11);
    fl_a = 1'b1;
    cyc(); fl_a = 1'b0; #2;
    check("fl_idle", irdy_a, 1'b1);
    check("fl_ren", ren_a, 2'b00);
    check("fl_ov", ov_a, 1'b0);
    cyc(); #2;
    check("fl_ov_later", ov_a, 1'b0);

    // STR r1,[r2] on two ports: single fetch cycle
    cyc(); iv_a = 1'b1; ins_a = 28'h5821000;
    cyc(); iv_a = 1'b0; #2;
    check("str2_ren", ren_a, 2'b11);
    check("str2_addr", raddr_a, 8'h12);
    cyc(); #2;
    check("str2_ov", ov_a, 1'b1);
    check("str2_mask", mask_a, 4'b1001);
    check("str2_rn", rn_a, rfv(4'd2));
    check("str2_rd", rd_a, rfv(4'd1));
    check("str2_rm", rm_a, 32'h0);
    ordy_a = 1'b1;
    cyc(); ordy_a = 1'b0;

    // Reset during FETCH of the ADD
    cyc(); iv_a = 1'b1; ins_a = 28'h0821413;
    cyc(); iv_a = 1'b0; #2;
    check("rs_fetch_ren", ren_a, 2'b11);
    rst_n = 1'b0; #1;
    check("rs_rdy", irdy_a, 1'b1);
    check("rs_ren", ren_a, 2'b00);
    check("rs_raddr", raddr_a, 8'h00);
    check("rs_ov", ov_a, 1'b0);
    check("rs_mask", mask_a, 4'h0);
    check("rs_rn", rn_a, 32'h0);
    cyc(); rst_n = 1'b1;

    // SWP: rn=5, rm=7
    cyc(); iv_a = 1'b1; ins_a = 28'h1054097;
    cyc(); iv_a = 1'b0; #2;
    check("swp_ren", ren_a, 2'b11);
    check("swp_addr", raddr_a, 8'h75);
    cyc(); #2;
    check("swp_ov", ov_a, 1'b1);
    check("swp_mask", mask_a, 4'b0011);
    check("swp_rn", rn_a, rfv(4'd5));
    check("swp_rm", rm_a, rfv(4'd7));
    ordy_a = 1'b1;
    cyc(); ordy_a = 1'b0;

    // Single-port instance
    run_b("str1", 28'h5821000, 4'b1001, 16'h1002);
    run_b("mla1", 28'h0213592, 4'b0111, 16'h0523);
    run_b("bx1",  28'h12FFF1E, 4'b0001, 16'h000E);
    run_b("stm1", 28'h92D4000, 4'b0001, 16'h000D);
    run_b("mov1", 28'h3A00005, 4'b0000, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_operand_fetch.md
REGISTER_OPERAND_FETCH -- requirements
Module: register_operand_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter READ_PORTS, default 2, register-file read ports used per cycle; legal values 1..4.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port instr_valid  in  1  instruction offered.
REQ-006 SHALL have port instr  in  28  instruction bits [27:0], condition field excluded.
REQ-007 SHALL have port instr_ready  out  1  instruction accepted when high with instr_valid.
REQ-008 SHALL have port flush  in  1  synchronous abort of the current instruction.
REQ-009 SHALL have port rf_ren  out  READ_PORTS  per-port read enable.
REQ-010 SHALL have port rf_raddr  out  4*READ_PORTS  per-port register index; port p at [4p+3:4p].
REQ-011 SHALL have port rf_rdata  in  DATA_W*READ_PORTS  per-port data, valid in the same cycle as rf_raddr.
REQ-012 SHALL have port op_valid  out  1  operand bundle valid.
REQ-013 SHALL have port op_ready  in  1  consumer accepts bundle.
REQ-014 SHALL have ports op_rn, op_rm, op_rs, op_rd  out  DATA_W each  operand values.
REQ-015 SHALL have port op_mask  out  4  slot-used flags {rd,rs,rm,rn}, bit0=rn.

Function
REQ-016 SHALL decode the slots on acceptance, first match wins: multiply (27:22=000000, 7:4=1001): rm=[3:0], rs=[11:8], rn=[15:12] only if bit21.
REQ-017 SHALL decode multiply long (27:23=00001, 7:4=1001) as rm=[3:0], rs=[11:8].
REQ-018 SHALL decode swap (27:23=00010, 21:20=00, 11:4=00001001) as rn=[19:16], rm=[3:0]; BX (27:4=0x12FFF1) as rn=[3:0].
REQ-019 SHALL decode halfword transfer (27:25=000, 7=1, 4=1) as rn=[19:16]; plus rm=[3:0] if bit22=0; plus rd=[15:12] if bit20=0.
REQ-020 SHALL decode other 27:26=00 as data processing: rn=[19:16] unless opcode [24:21] is 1101 or 1111; rm=[3:0] if bit25=0; rs=[11:8] if bit25=0 and bit4=1.
REQ-021 SHALL decode 27:26=01 with bit25=0 or bit4=0 as single transfer: rn=[19:16]; rm=[3:0] if bit25=1; rd=[15:12] if bit20=0.
REQ-022 SHALL decode 27:25=100 as rn=[19:16] only; every other encoding uses no slots.
REQ-023 SHALL implement states IDLE, FETCH, DONE; instr_ready=1 only in IDLE.
REQ-024 SHALL on acceptance latch slot indices and op_mask, go to FETCH if op_mask!=0, else DONE.
REQ-025 SHALL in FETCH assign up to READ_PORTS pending slots per cycle to ports 0,1,... in order rn, rm, rs, rd, asserting rf_ren only on used ports; rf_raddr of unused ports SHALL be 0.
REQ-026 SHALL capture rf_rdata into the matching op_* register at the clock edge ending each FETCH cycle; FETCH lasts ceil(popcount(op_mask)/READ_PORTS) cycles, then DONE.
REQ-027 SHALL hold op_valid=1 in DONE; op_valid&op_ready moves to IDLE; op_* and op_mask SHALL stay stable while op_valid=1 and op_ready=0.
REQ-028 SHALL drive op_* of unused slots as 0.
REQ-029 SHALL on flush=1 in any state go to IDLE at the next edge, clearing op_valid and rf_ren; flush has priority over acceptance and handshake in that cycle.

Reset
REQ-030 SHALL on rst_n=0 immediately force IDLE, instr_ready=1 after release, op_valid=0, rf_ren=0, rf_raddr=0, op_*=0, op_mask=0; an in-flight instruction SHALL be discarded.

Verification
REQ-031 SHALL check READ_PORTS=2, instr=0x0821413 (ADD r1,r2,r3 LSL r4) -> cycle1 raddr {3,2}, cycle2 raddr {_,4} ren=01, then op_valid, op_mask=0111.
REQ-032 SHALL check instr=0x3A00005 (MOV r0,#5) -> no rf_ren, op_valid one cycle after acceptance, op_mask=0000, op_*=0.
REQ-033 SHALL check READ_PORTS=1, instr=0x5821000 (STR r1,[r2]) -> raddr 2 then 1 over two cycles, op_mask=1001, op_rd=rdata of r1.
REQ-034 SHALL check op_ready=0 for 5 cycles in DONE -> outputs stable, instr_ready=0; op_ready=1 -> IDLE next cycle.
REQ-035 SHALL check flush and, separately, rst_n=0 during FETCH of REQ-031 -> IDLE next edge / immediately, op_valid never asserted, next instruction decoded correctly.
